// File: rtl/fib_scroll_disp.sv
// Fibonacci/Lucas table generator feeding a two-row scrolling ASCII display.
// Latency: DEPTH cycles to build the table, rows follow the scroll position one cycle later.
// Backpressure: none; restart preempts everything, pause freezes the scroll timer.
module fib_scroll_disp #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 25,
    parameter int TICK_CYCLES = 70_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode,
    input  logic         restart,
    input  logic         dir_toggle,
    input  logic         pause,
    input  logic         step,
    output logic [127:0] row_A,
    output logic [127:0] row_B,
    output logic         busy,
    output logic         ovf,
    output logic [7:0]   cur_idx
);

    localparam int             IW        = $clog2(DEPTH);
    localparam int             TW        = $clog2(TICK_CYCLES);
    localparam logic [7:0]     LAST      = 8'(DEPTH - 1);
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [127:0]   BLANK_ROW = {16{8'h20}};
    localparam logic [31:0]    FIB_TAG   = "Fib ";
    localparam logic [31:0]    LUC_TAG   = "Luc ";

    typedef enum logic [1:0] {IDLE, GEN, DISP} state_t;

    state_t              state, state_nxt;
    logic                gen_start;
    logic                advance;
    logic                dir;
    logic                dir_nxt;
    logic [7:0]          g;
    logic [7:0]          p;
    logic [7:0]          p_nxt;
    logic [7:0]          q;
    logic                mode_q;
    logic [DATA_W-1:0]   term_a;
    logic [DATA_W-1:0]   term_b;
    logic [DATA_W-1:0]   term;
    logic [DATA_W:0]     sum;
    logic                sat;
    logic [TW-1:0]       tick_cnt;
    logic [DATA_W-1:0]   tbl [DEPTH];

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [127:0] fmt_row(input logic lucas, input logic [7:0] idx,
                                             input logic [DATA_W-1:0] val);
        logic [7:0]  num;
        logic [31:0] v;
        logic [63:0] field;
        num   = idx + 8'd1;
        v     = 32'(val);
        field = '0;
        // value is right-justified in the 8-character field, blank-padded on the left
        for (int i = 0; i < 8; i++) begin
            field[8*i +: 8] = (i < DATA_W/4) ? hex_char(v[4*i +: 4]) : 8'h20;
        end
        return {(lucas ? LUC_TAG : FIB_TAG), 8'h23, hex_char(num[7:4]), hex_char(num[3:0]),
                8'h20, field};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gen_start = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = GEN;
                gen_start = 1'b1;
            end
            GEN: begin
                busy = 1'b1;
                if (g == LAST) state_nxt = DISP;
            end
            DISP: state_nxt = DISP;
            default: state_nxt = IDLE;
        endcase
        if (restart) begin
            state_nxt = GEN;
            gen_start = 1'b1;
        end
    end

    // dir = 1 scrolls downwards; a toggle coinciding with an advance steers that advance
    always_comb begin
        dir_nxt = dir ^ dir_toggle;
        advance = 1'b0;
        if (state == DISP && !restart) begin
            if (pause) advance = step;
            else       advance = (tick_cnt == TICK_LAST);
        end
        if (dir_nxt) p_nxt = (p == 8'd0) ? LAST : p - 8'd1;
        else         p_nxt = (p == LAST) ? 8'd0 : p + 8'd1;
        q = (p == LAST) ? 8'd0 : p + 8'd1;
    end

    always_comb begin
        sum  = {1'b0, term_a} + {1'b0, term_b};
        sat  = 1'b0;
        term = sum[DATA_W-1:0];
        if (g == 8'd0) begin
            term = mode_q ? DATA_W'(2) : '0;
        end else if (g == 8'd1) begin
            term = DATA_W'(1);
        end else if (sum[DATA_W] || (&term_a) || (&term_b)) begin
            term = '1;
            sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir      <= 1'b0;
            g        <= 8'd0;
            mode_q   <= 1'b0;
            ovf      <= 1'b0;
            term_a   <= '0;
            term_b   <= '0;
            p        <= 8'd0;
            tick_cnt <= '0;
            row_A    <= BLANK_ROW;
            row_B    <= BLANK_ROW;
        end else begin
            dir <= dir_nxt;
            if (gen_start) begin
                g      <= 8'd0;
                mode_q <= mode;
                ovf    <= 1'b0;
            end else if (state == GEN) begin
                g      <= g + 8'd1;
                term_a <= term;
                term_b <= term_a;
                if (sat) ovf <= 1'b1;
                if (g == LAST) begin
                    p        <= 8'd0;
                    tick_cnt <= '0;
                end
            end else if (state == DISP) begin
                row_A <= fmt_row(mode_q, p, tbl[p[IW-1:0]]);
                row_B <= fmt_row(mode_q, q, tbl[q[IW-1:0]]);
                if (advance) p <= p_nxt;
                if (pause) begin
                    if (step) tick_cnt <= '0;
                end else if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == GEN && !restart) tbl[g[IW-1:0]] <= term;
    end

    assign cur_idx = p;

endmodule

// File: tb/tb_fib_scroll_disp.sv
// Directed bench for fib_scroll_disp with DATA_W=16, DEPTH=25, TICK_CYCLES=10.
module tb_fib_scroll_disp;

    logic         clk = 1'b0;
    logic         reset;
    logic         mode;
    logic         restart;
    logic         dir_toggle;
    logic         pause;
    logic         step;
    logic [127:0] row_A;
    logic [127:0] row_B;
    logic         busy;
    logic         ovf;
    logic [7:0]   cur_idx;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLANK = {16{8'h20}};

    always #5 clk = ~clk;

    fib_scroll_disp #(.DATA_W(16), .DEPTH(25), .TICK_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .restart    (restart),
        .dir_toggle (dir_toggle),
        .pause      (pause),
        .step       (step),
        .row_A      (row_A),
        .row_B      (row_B),
        .busy       (busy),
        .ovf        (ovf),
        .cur_idx    (cur_idx)
    );

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy_rise(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            cyc();
            n++;
        end
        chk(tag, 128'(busy), 128'd1);
    endtask

    task automatic gen_len(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        chk(tag, 128'(n), 128'd25);
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; restart = 1'b0;
        dir_toggle = 1'b0; pause = 1'b0; step = 1'b0;
        cyc(3);
        chk("rst_row_A", row_A, BLANK);
        chk("rst_row_B", row_B, BLANK);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ovf", 128'(ovf), 128'd0);
        chk("rst_idx", 128'(cur_idx), 128'd0);

        // Fibonacci generation after reset release
        reset = 1'b0;
        wait_busy_rise("busy_rise_fib");
        gen_len("gen_len_fib");
        chk("fib_ovf", 128'(ovf), 128'd0);
        cyc();
        chk("fib_row_A0", row_A, "Fib #01     0000");
        chk("fib_row_B0", row_B, "Fib #02     0001");
        chk("fib_idx0", 128'(cur_idx), 128'd0);
        cyc(9);
        chk("adv_idx1", 128'(cur_idx), 128'd1);
        chk("row_lag", row_A, "Fib #01     0000");
        cyc();
        chk("row_A1", row_A, "Fib #02     0001");
        cyc(20);
        chk("idx3", 128'(cur_idx), 128'd3);
        chk("row_A3", row_A, "Fib #04     0002");
        chk("row_B3", row_B, "Fib #05     0003");

        // Lucas regeneration with saturation of the last term
        mode = 1'b1; restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("luc_busy", 128'(busy), 128'd1);
        chk("luc_hold_A", row_A, "Fib #04     0002");
        gen_len("gen_len_luc");
        chk("luc_ovf", 128'(ovf), 128'd1);
        chk("luc_hold_A2", row_A, "Fib #04     0002");
        cyc();
        chk("luc_row_A0", row_A, "Luc #01     0002");
        chk("luc_row_B0", row_B, "Luc #02     0001");
        dir_toggle = 1'b1;
        cyc();
        dir_toggle = 1'b0;
        cyc(9);
        chk("luc_wrap_idx", 128'(cur_idx), 128'd24);
        chk("luc_sat_A", row_A, "Luc #19     FFFF");
        chk("luc_wrap_B", row_B, "Luc #01     0002");
        cyc(10);
        chk("luc_idx23", 128'(cur_idx), 128'd23);
        chk("luc_t23_A", row_A, "Luc #18     FA4F");
        chk("luc_t24_B", row_B, "Luc #19     FFFF");
        cyc(8);
        dir_toggle = 1'b1;
        cyc();
        dir_toggle = 1'b0;
        chk("toggle_on_adv", 128'(cur_idx), 128'd24);

        // Back to Fibonacci; ovf clears on restart, rows hold during GEN
        mode = 1'b0; restart = 1'b1;
        cyc();
        restart = 1'b0;
        chk("rst_ovf_clr", 128'(ovf), 128'd0);
        chk("fib2_hold_A", row_A, "Luc #18     FA4F");
        gen_len("gen_len_fib2");
        cyc();
        chk("fib2_row_A0", row_A, "Fib #01     0000");
        chk("fib2_idx0", 128'(cur_idx), 128'd0);
        dir_toggle = 1'b1;
        cyc();
        dir_toggle = 1'b0;
        cyc(9);
        chk("down_idx24", 128'(cur_idx), 128'd24);
        chk("down_row_A", row_A, "Fib #19     B520");
        chk("down_row_B", row_B, "Fib #01     0000");

        // Pause, single step, and resumption timing
        pause = 1'b1;
        cyc(50);
        chk("pause_idx", 128'(cur_idx), 128'd24);
        chk("pause_row_A", row_A, "Fib #19     B520");
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_idx", 128'(cur_idx), 128'd23);
        cyc();
        chk("step_row_A", row_A, "Fib #18     6FF1");
        chk("step_row_B", row_B, "Fib #19     B520");
        cyc(2);
        chk("step_once", 128'(cur_idx), 128'd23);
        pause = 1'b0;
        cyc(9);
        chk("resume_early", 128'(cur_idx), 128'd23);
        cyc();
        chk("resume_adv", 128'(cur_idx), 128'd22);
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("step_unpaused", 128'(cur_idx), 128'd22);
        cyc(9);
        chk("tick_intact", 128'(cur_idx), 128'd21);

        // Asynchronous reset in the middle of generation
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        cyc(10);
        reset = 1'b1;
        #2;
        chk("mid_rst_row_A", row_A, BLANK);
        chk("mid_rst_row_B", row_B, BLANK);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_idx", 128'(cur_idx), 128'd0);
        cyc(2);
        reset = 1'b0;
        wait_busy_rise("busy_rise_rst");
        gen_len("gen_len_rst");
        cyc();
        chk("post_rst_row_A", row_A, "Fib #01     0000");
        chk("post_rst_row_B", row_B, "Fib #02     0001");
        cyc(9);
        chk("post_rst_dir_up", 128'(cur_idx), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
